// File: rtl/mult_unit.sv
// Unsigned sequential shift-add multiplier for the MULTU path.
// WIDTH iterations per product. HI/LO change only when a product completes,
// so rd_data never shows partial results. stall holds MULTU/MFHI/MFLO in the
// pipeline while a multiply is still running.
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sfmux_high,
    input  logic             sf2reg,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    // Upper half is the accumulator; lower half starts as the multiplier and
    // fills with product bits as it shifts right.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic               last_iter;

    // One shift-add step: conditional add into the upper half with carry, then shift right.
    always_comb begin
        sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nx   = {sum, prod_q[WIDTH-1:1]};
        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state logic: accept a start in IDLE, iterate in RUN, commit HI/LO on the last step.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mult_enable) begin
                    mcand_d = a;
                    prod_d  = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                prod_d = prod_nx;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_d    = prod_nx[2*WIDTH-1:WIDTH];
                    lo_d    = prod_nx[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any multiply in flight and clears HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Outputs: result mux and the stall request to the datapath.
    always_comb begin
        busy    = (state_q == RUN);
        done    = done_q;
        stall   = busy & (mult_enable | sf2reg);
        rd_data = sfmux_high ? hi_q : lo_q;
    end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: random operands against a plain
// 64-bit multiply reference, plus the directed corner and control scenarios.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         mult_enable;
    logic [W-1:0] a_i, b_i;
    logic         sfmux_high;
    logic         sf2reg;
    logic [W-1:0] rd_data;
    logic         busy, done, stall;

    int checks = 0;
    int errors = 0;

    // Reference architectural state: what HI/LO should hold.
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mult_enable(mult_enable), .a(a_i), .b(b_i),
        .sfmux_high(sfmux_high), .sf2reg(sf2reg), .rd_data(rd_data),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return p;
    endfunction

    // Drive a one-cycle start request; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a_i = x; b_i = y; mult_enable = 1'b1;
        @(negedge clk);
        mult_enable = 1'b0;
    endtask

    // Runs from the first negedge after acceptance until done. Checks busy,
    // stall and that rd_data keeps the old HI/LO. inj: busy cycle at which a
    // stray start (a=b=1) is raised for one cycle (-1 = none).
    task automatic wait_done(input int inj, input bit hold_sf2reg, output int bcyc);
        logic exp_stall;
        bcyc = 0;
        sf2reg = hold_sf2reg;
        for (int n = 0; n < 100; n++) begin
            if (done) break;
            if (busy) bcyc++;
            if (bcyc == inj) begin
                mult_enable = 1'b1; a_i = 1; b_i = 1;
            end
            sfmux_high = 1'($urandom);
            #1;
            exp_stall = mult_enable | sf2reg;
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL stall_run cyc=%0d got=%b exp=%b", bcyc, stall, exp_stall);
            end
            checks++;
            if (rd_data !== (sfmux_high ? exp_hi : exp_lo)) begin
                errors++;
                $display("FAIL hold_hilo cyc=%0d sel=%b got=%h exp=%h", bcyc, sfmux_high, rd_data,
                         sfmux_high ? exp_hi : exp_lo);
            end
            @(negedge clk);
            mult_enable = 1'b0;
        end
        sf2reg = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_timeout busy_cycles=%0d done=%b busy=%b", bcyc, done, busy);
        end
        checks++;
        if (bcyc != W) begin
            errors++;
            $display("FAIL latency got=%0d exp=%0d", bcyc, W);
        end
    endtask

    // Compare HI and LO through the read mux against the reference.
    task automatic check_result(input string name);
        sfmux_high = 1'b1; #1;
        checks++;
        if (rd_data !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi got=%h exp=%h", name, rd_data, exp_hi);
        end
        sfmux_high = 1'b0; #1;
        checks++;
        if (rd_data !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo got=%h exp=%h", name, rd_data, exp_lo);
        end
    endtask

    task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y, input string name);
        int bc;
        logic [2*W-1:0] p;
        start_op(x, y);
        wait_done(-1, 1'b0, bc);
        p = ref_mul(x, y);
        exp_hi = p[2*W-1:W];
        exp_lo = p[W-1:0];
        check_result(name);
        // done lasts exactly one cycle
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width got=%b exp=0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mult_enable = 1'b0; a_i = '0; b_i = '0; sfmux_high = 1'b1; sf2reg = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000", {busy, done, stall});
        end
        exp_hi = '0; exp_lo = '0;
        sf2reg = 1'b0;
        check_result("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run_mult(32'd3, 32'd5, "mul3x5");
    endtask

    task automatic test_corners;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_sq");
        run_mult(32'h8000_0000, 32'd2, "msb_x2");
        run_mult(32'h0, 32'h0, "zero");
        run_mult(32'h1234_5678, 32'h0, "times0");
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) run_mult($urandom, $urandom, "rand");
    endtask

    // Stray start mid-run: stalled, ignored, operands not resampled.
    task automatic test_ignore_enable;
        int bc;
        logic [2*W-1:0] p;
        start_op(32'd7, 32'd9);
        wait_done(10, 1'b0, bc);
        p = ref_mul(32'd7, 32'd9);
        exp_hi = p[2*W-1:W]; exp_lo = p[W-1:0];
        check_result("ignore_en");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL no_restart busy got=%b exp=0", busy);
        end
    endtask

    // MFHI/MFLO waiting on a running multiply sees old values until done.
    task automatic test_sf2reg;
        int bc;
        logic [2*W-1:0] p;
        logic [W-1:0] x, y;
        x = $urandom; y = $urandom;
        start_op(x, y);
        wait_done(-1, 1'b1, bc);
        p = ref_mul(x, y);
        exp_hi = p[2*W-1:W]; exp_lo = p[W-1:0];
        check_result("sf2reg");
    endtask

    task automatic test_reset_mid;
        int seen_done;
        start_op(32'hDEAD_BEEF, 32'h1234_5678);
        repeat (9) @(negedge clk);
        rst = 1'b1; #1;
        exp_hi = '0; exp_lo = '0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_ctrl got=%b exp=00", {busy, done});
        end
        check_result("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL mid_reset_activity got=%0d exp=0", seen_done);
        end
        check_result("after_reset");
        run_mult($urandom, $urandom, "post_reset");
    endtask

    // Second start on the done cycle goes straight into RUN.
    task automatic test_back_to_back;
        int bc;
        logic [2*W-1:0] p;
        start_op(32'd11, 32'd13);
        wait_done(-1, 1'b0, bc);
        p = ref_mul(32'd11, 32'd13);
        exp_hi = p[2*W-1:W]; exp_lo = p[W-1:0];
        a_i = 32'd2; b_i = 32'd3; mult_enable = 1'b1;
        check_result("b2b_first");
        @(negedge clk);
        mult_enable = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy got=%b exp=1", busy);
        end
        wait_done(-1, 1'b0, bc);
        exp_hi = '0; exp_lo = 32'd6;
        check_result("b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_ignore_enable();
        test_sf2reg();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; HI and LO are each WIDTH bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mult_enable  input  1  start request from the control decoder (MULTU); sampled on clk.
REQ-005 a  input  WIDTH  multiplicand (rs); sampled only when a start is accepted.
REQ-006 b  input  WIDTH  multiplier (rt); sampled only when a start is accepted.
REQ-007 sfmux_high  input  1  read select: 1 = HI, 0 = LO.
REQ-008 sf2reg  input  1  the current instruction reads HI or LO (MFHI/MFLO).
REQ-009 rd_data  output  WIDTH  combinational: sfmux_high ? HI : LO.
REQ-010 busy  output  1  high while a multiply is in progress.
REQ-011 done  output  1  one-cycle pulse when HI/LO have just been updated.
REQ-012 stall  output  1  combinational pipeline stall request to the datapath.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN; busy = (state == RUN).
REQ-014 In IDLE, mult_enable=1 at a rising edge SHALL be accepted: latch a into mcand, latch b into the multiplier shift register, clear the 2*WIDTH accumulator, set cnt=0, and enter RUN.
REQ-015 In RUN, each cycle SHALL do the following: if the multiplier LSB is 1, add mcand to the upper WIDTH bits of the accumulator with carry-out kept (WIDTH+1-bit add); shift {carry, accumulator, multiplier} right by one; increment cnt.
REQ-016 The arithmetic SHALL be unsigned; the full 2*WIDTH-bit product SHALL be exact, with no truncation or overflow.
REQ-017 On the edge that completes the WIDTH-th iteration, the block SHALL write HI = product[2*WIDTH-1:WIDTH] and LO = product[WIDTH-1:0], return to IDLE, and assert done for the following cycle only.
REQ-018 Latency: if a start is accepted at edge t, HI/LO SHALL update at edge t+WIDTH; busy is high from t through t+WIDTH; done is high between t+WIDTH and t+WIDTH+1.
REQ-019 HI and LO SHALL hold their previous values throughout RUN; partial products are never visible on rd_data.
REQ-020 mult_enable in RUN SHALL be ignored: no restart, and operands are not resampled.
REQ-021 stall SHALL equal busy & (mult_enable | sf2reg), so the requesting instruction is held until the result is ready.
REQ-022 A start SHALL be accepted on the cycle done is high (state is IDLE), giving back-to-back multiplies with no gap cycle.
REQ-023 cnt SHALL be wide enough to hold WIDTH without wrap; iteration count SHALL be exactly WIDTH for every operand pair, including zero.
REQ-024 When WIDTH=32, rd_data SHALL change only with sfmux_high or at the HI/LO update edge.

Reset
REQ-025 While rst is high, regardless of clk: state=IDLE, HI=0, LO=0, accumulator=0, cnt=0, busy=0, done=0; therefore stall=0 and rd_data=0.
REQ-026 Reset mid-RUN SHALL abort the operation, leave no partial result in HI/LO, and assert no done pulse.
REQ-027 After rst deasserts, the first rising edge with mult_enable=1 SHALL start a multiply normally.

Verification
REQ-028 a=3, b=5, pulse mult_enable -> busy high 32 cycles, done pulse once, HI=0x00000000, LO=0x0000000F.
REQ-029 a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; a=0x80000000, b=2 -> HI=0x00000001, LO=0x00000000.
REQ-030 Start 7*9, then at cycle 10 assert mult_enable=1 with a=b=1 -> stall=1 that cycle, result is still LO=63, and no restart.
REQ-031 Prior HI/LO=(0x12,0x34); start new multiply; hold sf2reg=1 with sfmux_high toggling during RUN -> stall=1, rd_data=0x12 or 0x34 until done, then the new values.
REQ-032 Start a multiply, assert rst at cycle 10 -> busy=0, done never pulses, HI=LO=0; next start completes correctly.
REQ-033 Issue a second start on the done cycle (a=2, b=3) -> accepted immediately; LO=6 exactly 32 cycles later.
